mem_addr_sequencer: RTL

MEM_ADDR_SEQUENCER -- requirements
Module: mem_addr_sequencer

---
 rtl/mem_addr_pkg.sv | 36 +++
 rtl/mem_addr_counter.sv | 41 ++++
 rtl/mem_addr_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_addr_pkg.sv
// ---------------------------------------------------------------------------
// mem_addr_pkg
//
// Purpose : Shared definitions for the memory address sequencer slice.
//           Holds the sequencer state encoding and the default widths used
//           by mem_addr_sequencer and mem_addr_counter.
//
// Contents:
//   DEF_IN_AW  - default logical word-address width
//   DEF_BANK_W - default bank-select width
//   DEF_LEN_W  - default transfer-length width (words)
//   state_t    - sequencer states IDLE / RUN / FINISH
//   is_last_word - helper that flags the final word of a pass
// ---------------------------------------------------------------------------
package mem_addr_pkg;

   localparam int DEF_IN_AW  = 24;
   localparam int DEF_BANK_W = 2;
   localparam int DEF_LEN_W  = 24;

   // IDLE waits for a request, RUN streams addresses, FINISH is the single
   // cycle that carries the done pulse before returning to IDLE.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_t;

   // The remaining-words counter holds the number of words still to be
   // handed over, including the one currently on the bus. A value of one
   // therefore marks the final word of the pass.
   function automatic logic is_last_word(input logic [DEF_LEN_W-1:0] remaining);
      return (remaining == DEF_LEN_W'(1));
   endfunction

endpackage

// File: rtl/mem_addr_counter.sv
// ---------------------------------------------------------------------------
// mem_addr_counter
//
// Purpose : Loadable up-counter for the logical word address. It wraps
//           naturally modulo 2^W, so the bank bits held elsewhere are never
//           disturbed when the logical address rolls over.
//
// Ports   :
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset, clears the count
//   load     in   load load_val on the next edge (has priority over en)
//   load_val in   W-bit value to load
//   en       in   increment by one on the next edge
//   q        out  current count
// ---------------------------------------------------------------------------
module mem_addr_counter
   import mem_addr_pkg::*;
#(
   parameter int W = DEF_IN_AW
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] q
);

   // Load wins over increment so that a pass restart (which happens on the
   // same cycle as a handshake) lands exactly on the reload value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= '0;
      end else if (load) begin
         q <= load_val;
      end else if (en) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/mem_addr_sequencer.sv
// ---------------------------------------------------------------------------
// mem_addr_sequencer
//
// Purpose : Generates a run of consecutive physical word addresses
//           {bank, logical} for a memory consumer using a valid/ready
//           handshake. One address is handed over per cycle in which
//           addr_valid and addr_ready are both high, with no bubbles.
//
// Optional feature (compile-time macro MEM_ADDR_LOOP_EN):
//   when defined, an extra input "loop" exists; a transfer started with
//   loop=1 restarts at base_addr after every pass, pulsing done each pass,
//   until abort or reset. When undefined every transfer is one-shot.
//
// Ports   :
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   start      in   single-cycle request to begin a transfer (IDLE only)
//   abort      in   cancel the transfer in progress (wins over everything)
//   base_addr  in   first logical word address
//   length     in   number of words; zero gives an empty transfer
//   bank       in   bank bits placed above the logical address
//   loop       in   repeat-forever request (MEM_ADDR_LOOP_EN builds only)
//   mem_addr   out  physical address {bank, logical}
//   addr_valid out  mem_addr is valid
//   addr_ready in   consumer accepts mem_addr this cycle
//   busy       out  high from accepted start until back in IDLE
//   done       out  one-cycle pulse at the end of each pass
// ---------------------------------------------------------------------------
module mem_addr_sequencer
   import mem_addr_pkg::*;
#(
   parameter int IN_AW  = DEF_IN_AW,
   parameter int BANK_W = DEF_BANK_W,
   parameter int LEN_W  = DEF_LEN_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    abort,
   input  logic [IN_AW-1:0]        base_addr,
   input  logic [LEN_W-1:0]        length,
   input  logic [BANK_W-1:0]       bank,
`ifdef MEM_ADDR_LOOP_EN
   input  logic                    loop,
`endif
   output logic [BANK_W+IN_AW-1:0] mem_addr,
   output logic                    addr_valid,
   input  logic                    addr_ready,
   output logic                    busy,
   output logic                    done
);

   state_t              state;

   logic [IN_AW-1:0]    base_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    remain_q;
   logic [BANK_W-1:0]   bank_q;
   logic                loop_q;

   logic [IN_AW-1:0]    addr_q;

   logic                accept;
   logic                xfer;
   logic                last_word;
   logic                restart;
   logic                cnt_load;
   logic                cnt_en;
   logic [IN_AW-1:0]    cnt_val;

   // The physical address is built from two registers, so it is glitch-free
   // and reads as zero straight out of reset.
   assign mem_addr = {bank_q, addr_q};

`ifdef MEM_ADDR_LOOP_EN
   // Remember the loop request of the accepted start; it only matters while
   // the sequencer is running, so it is simply overwritten by the next start.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loop_q <= 1'b0;
      end else if (accept) begin
         loop_q <= loop;
      end
   end
`else
   assign loop_q = 1'b0;
`endif

   // Decode of the events that move the sequencer. Abort masks both a new
   // start and a handshake, so it always has the final say. The word counter
   // is compared at the original length width, so the full 2^LEN_W-1 range
   // completes without any extra carry bit.
   always_comb begin
      accept    = 1'b0;
      xfer      = 1'b0;
      last_word = 1'b0;
      restart   = 1'b0;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
      cnt_val   = base_q;

      accept    = (state == IDLE) && start && !abort;
      xfer      = (state == RUN) && addr_valid && addr_ready && !abort;
      last_word = xfer && (remain_q == LEN_W'(1));
      restart   = last_word && loop_q;

      cnt_load  = accept || restart;
      cnt_val   = accept ? base_addr : base_q;
      cnt_en    = xfer && !last_word;
   end

   // Logical address counter. It is loaded with base_addr on an accepted
   // start and again on a looped restart, and steps once per handshake.
   mem_addr_counter #(
      .W        (IN_AW)
   ) u_addr_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .en       (cnt_en),
      .q        (addr_q)
   );

   // Main control FSM with registered handshake/status outputs. addr_valid
   // is cleared on the same edge as the final handshake so the consumer never
   // sees a stale extra word. done is a default-low pulse raised only when a
   // pass completes normally; abort paths never raise it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         base_q     <= '0;
         len_q      <= '0;
         remain_q   <= '0;
         bank_q     <= '0;
         addr_valid <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         done <= 1'b0;

         case (state)
            IDLE: begin
               addr_valid <= 1'b0;
               busy       <= 1'b0;
               if (accept) begin
                  base_q <= base_addr;
                  len_q  <= length;
                  bank_q <= bank;
                  busy   <= 1'b1;
                  if (length == '0) begin
                     state    <= FINISH;
                     remain_q <= '0;
                     done     <= 1'b1;
                  end else begin
                     state      <= RUN;
                     remain_q   <= length;
                     addr_valid <= 1'b1;
                  end
               end
            end

            RUN: begin
               if (abort) begin
                  state      <= IDLE;
                  remain_q   <= '0;
                  addr_valid <= 1'b0;
                  busy       <= 1'b0;
               end else if (xfer) begin
                  if (last_word) begin
                     done <= 1'b1;
                     if (loop_q) begin
                        remain_q <= len_q;
                     end else begin
                        state      <= FINISH;
                        remain_q   <= '0;
                        addr_valid <= 1'b0;
                     end
                  end else begin
                     remain_q <= remain_q - LEN_W'(1);
                  end
               end
            end

            FINISH: begin
               state      <= IDLE;
               addr_valid <= 1'b0;
               busy       <= 1'b0;
            end

            default: begin
               state      <= IDLE;
               remain_q   <= '0;
               addr_valid <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
